// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the dpram port arbiter: FSM state encoding,
// requester-count limits and the index-width helper.
package dpram_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

    // Width of a requester index; never below one bit so NREQ=2 still gets a real signal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping modulo NREQ. Returns a one-hot grant and the matching index.
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one dpram port among NREQ requesters: round-robin grant with burst lock,
// read responses returned one cycle later and tagged to the issuing requester.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DATA = 16,
    parameter int ADDR = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*ADDR-1:0] req_addr,
    input  logic [NREQ*DATA-1:0] req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DATA-1:0]      rsp_rdata,
    output logic                 ram_we,
    output logic [ADDR-1:0]      ram_addr,
    output logic [DATA-1:0]      ram_din,
    input  logic [DATA-1:0]      ram_dout
);

    localparam int            IW       = clog2(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    arb_state_e      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   next_ptr;
    logic            beat;
    logic [ADDR-1:0] addr_q;
    logic [DATA-1:0] din_q;
    logic [NREQ-1:0] vld_p1;

    logic [ADDR-1:0] addr_arr [NREQ];
    logic [DATA-1:0] wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR +: ADDR];
        assign wdata_arr[i] = req_wdata[i*DATA +: DATA];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Grant is suppressed while reset is held so nothing reaches the RAM during reset.
    always_comb begin
        grant = '0;
        gidx  = owner;
        if (rst_n) begin
            if (state == IDLE) begin
                grant = pick_grant;
                gidx  = pick_idx;
            end else begin
                grant[owner] = req_valid[owner];
            end
        end
    end

    assign beat      = |grant;
    assign req_ready = grant;
    assign next_ptr  = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;

    // Idle cycles replay the last accepted beat's address/data so bystanders cannot toggle the RAM pins.
    assign ram_we    = beat & req_we[gidx];
    assign ram_addr  = beat ? addr_arr[gidx]  : addr_q;
    assign ram_din   = beat ? wdata_arr[gidx] : din_q;

    assign rsp_valid = vld_p1;
    assign rsp_rdata = ram_dout;

    // p0 -> p1: accepted read beat becomes a response tag aligned with the RAM output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            vld_p1 <= '0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            vld_p1 <= (beat && !req_we[gidx]) ? grant : '0;
            if (beat) begin
                addr_q <= ram_addr;
                din_q  <= ram_din;
                if (req_last[gidx]) begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr;
                end else begin
                    state  <= LOCKED;
                    owner  <= gidx;
                end
            end
        end
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench: arbiter on port A of a read-first dual-port RAM, port B driven directly.
module tb_dpram_port_arbiter;

    localparam int NREQ = 4;
    localparam int DATA = 16;
    localparam int ADDR = 5;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_we;
    logic [NREQ-1:0]      req_last;
    logic [NREQ*ADDR-1:0] req_addr;
    logic [NREQ*DATA-1:0] req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [DATA-1:0]      rsp_rdata;
    logic                 ram_we;
    logic [ADDR-1:0]      ram_addr;
    logic [DATA-1:0]      ram_din;
    logic [DATA-1:0]      ram_dout;

    logic                 web;
    logic [ADDR-1:0]      addrb;
    logic [DATA-1:0]      dinb;
    logic [DATA-1:0]      doutb;

    logic [ADDR-1:0]      t_addr  [NREQ];
    logic [DATA-1:0]      t_wdata [NREQ];
    logic [DATA-1:0]      mem     [32];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_addr[g*ADDR +: ADDR]  = t_addr[g];
        assign req_wdata[g*DATA +: DATA] = t_wdata[g];
    end

    dpram_port_arbiter #(
        .NREQ (NREQ),
        .DATA (DATA),
        .ADDR (ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Read-first dual-port RAM with registered outputs.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        doutb    <= mem[addrb];
        if (ram_we) mem[ram_addr] <= ram_din;
        if (web)    mem[addrb]    <= dinb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_we    = '0;
        req_last  = '0;
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
    endtask

    task automatic set_req(input logic [1:0] i, input logic we, input logic last,
                           input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_last[i]  = last;
        t_addr[i]    = a;
        t_wdata[i]   = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        idle_all();
        web   = 1'b0;
        addrb = '0;
        dinb  = '0;

        // Reset with every requester asking: nothing may leak out.
        req_valid = '1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready",   32'(req_ready), 32'h0);
        check("rst_we",      32'(ram_we),    32'h0);
        check("rst_addr",    32'(ram_addr),  32'h0);
        check("rst_din",     32'(ram_din),   32'h0);
        check("rst_rsp",     32'(rsp_valid), 32'h0);
        tick();
        tick();
        idle_all();
        rst_n = 1'b1;

        // Single write then read by req0.
        set_req(2'd0, 1'b1, 1'b1, 5'd3, 16'hBEEF);
        #1;
        check("wr_ready", 32'(req_ready), 32'h1);
        check("wr_we",    32'(ram_we),    32'h1);
        check("wr_addr",  32'(ram_addr),  32'h3);
        check("wr_din",   32'(ram_din),   32'hBEEF);
        tick();
        idle_all();
        set_req(2'd0, 1'b0, 1'b1, 5'd3, 16'h0);
        #1;
        check("rd_ready", 32'(req_ready), 32'h1);
        check("rd_we",    32'(ram_we),    32'h0);
        check("wr_norsp", 32'(rsp_valid), 32'h0);
        tick();
        idle_all();
        set_req(2'd3, 1'b0, 1'b1, 5'd0, 16'h0);
        #1;
        check("rd_rsp",   32'(rsp_valid), 32'h1);
        check("rd_data",  32'(rsp_rdata), 32'hBEEF);
        check("r3_ready", 32'(req_ready), 32'h8);
        tick();

        // Round robin from rr_ptr=0 with all requesters valid.
        for (int k = 0; k < 5; k++) begin
            idle_all();
            for (int i = 0; i < NREQ; i++) set_req(2'(i), 1'b0, 1'b1, 5'd3, 16'h0);
            #1;
            check("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k == 0) check("rr_rsp", 32'(rsp_valid), 32'h8);
            else begin
                check("rr_rsp",  32'(rsp_valid), 32'(4'b0001 << ((k - 1) % 4)));
                check("rr_data", 32'(rsp_rdata), 32'hBEEF);
            end
            tick();
        end
        idle_all();
        #1;
        check("rr_rsp_last", 32'(rsp_valid), 32'h1);
        tick();

        // req1 write burst of 4 holds the port while req2 waits, then req2 reads it back.
        for (int b = 0; b < 8; b++) begin
            idle_all();
            if (b < 4) begin
                set_req(2'd1, 1'b1, 1'(b == 3), 5'(8 + b), 16'(16'hA001 + b));
                set_req(2'd2, 1'b0, 1'b0, 5'd8, 16'h0);
            end else begin
                set_req(2'd2, 1'b0, 1'(b == 7), 5'(8 + b - 4), 16'h0);
            end
            #1;
            check("bl_grant", 32'(req_ready), (b < 4) ? 32'h2 : 32'h4);
            check("bl_we",    32'(ram_we),    (b < 4) ? 32'h1 : 32'h0);
            check("bl_addr",  32'(ram_addr),  (b < 4) ? 32'(8 + b) : 32'(8 + b - 4));
            if (b >= 5) begin
                check("bl_rsp",  32'(rsp_valid), 32'h4);
                check("bl_data", 32'(rsp_rdata), 32'(16'hA001 + (b - 5)));
            end else begin
                check("bl_rsp",  32'(rsp_valid), 32'h0);
            end
            tick();
        end
        idle_all();
        #1;
        check("bl_rsp_last",  32'(rsp_valid), 32'h4);
        check("bl_data_last", 32'(rsp_rdata), 32'hA004);
        tick();

        // req3 owns the port, pauses two cycles; req0 must wait throughout.
        set_req(2'd3, 1'b1, 1'b0, 5'd20, 16'hC001);
        set_req(2'd0, 1'b0, 1'b1, 5'd3, 16'h0);
        #1;
        check("op_grant0", 32'(req_ready), 32'h8);
        check("op_we0",    32'(ram_we),    32'h1);
        tick();
        for (int p = 0; p < 2; p++) begin
            idle_all();
            set_req(2'd0, 1'b0, 1'b1, 5'd3, 16'h0);
            #1;
            check("op_pause_grant", 32'(req_ready), 32'h0);
            check("op_pause_we",    32'(ram_we),    32'h0);
            check("op_hold_addr",   32'(ram_addr),  32'd20);
            check("op_hold_din",    32'(ram_din),   32'hC001);
            tick();
        end
        set_req(2'd3, 1'b1, 1'b1, 5'd21, 16'hC002);
        #1;
        check("op_resume", 32'(req_ready), 32'h8);
        check("op_addr",   32'(ram_addr),  32'd21);
        tick();
        idle_all();
        set_req(2'd0, 1'b0, 1'b1, 5'd20, 16'h0);
        #1;
        check("op_next", 32'(req_ready), 32'h1);
        tick();
        idle_all();
        #1;
        check("op_rsp",  32'(rsp_valid), 32'h1);
        check("op_data", 32'(rsp_rdata), 32'hC001);
        tick();

        // Reset during req2's second read beat.
        set_req(2'd2, 1'b0, 1'b0, 5'd8, 16'h0);
        #1;
        check("mr_grant", 32'(req_ready), 32'h4);
        tick();
        idle_all();
        set_req(2'd2, 1'b0, 1'b0, 5'd9, 16'h0);
        rst_n = 1'b0;
        #1;
        check("mr_rsp",   32'(rsp_valid), 32'h0);
        check("mr_ready", 32'(req_ready), 32'h0);
        check("mr_we",    32'(ram_we),    32'h0);
        check("mr_addr",  32'(ram_addr),  32'h0);
        tick();
        rst_n = 1'b1;
        idle_all();
        for (int i = 0; i < NREQ; i++) set_req(2'(i), 1'b0, 1'b1, 5'd3, 16'h0);
        #1;
        check("mr_after_grant", 32'(req_ready), 32'h1);
        tick();
        idle_all();
        #1;
        check("mr_after_rsp", 32'(rsp_valid), 32'h1);
        tick();

        // Read-first collision between arbiter write and port B read.
        set_req(2'd0, 1'b1, 1'b1, 5'd5, 16'h2222);
        tick();
        idle_all();
        set_req(2'd0, 1'b1, 1'b1, 5'd5, 16'h1111);
        addrb = 5'd5;
        #1;
        check("rf_we",  32'(ram_we),  32'h1);
        check("rf_din", 32'(ram_din), 32'h1111);
        tick();
        idle_all();
        addrb = 5'd0;
        set_req(2'd0, 1'b0, 1'b1, 5'd5, 16'h0);
        #1;
        check("rf_portb", 32'(doutb), 32'h2222);
        tick();
        idle_all();
        #1;
        check("rf_rsp",  32'(rsp_valid), 32'h1);
        check("rf_data", 32'(rsp_rdata), 32'h1111);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
